// File: rtl/upsample_ctrl.sv
// Up-sampling sequencer: buffers low-rate samples and emits one real sample every FACTOR clocks.
// Optional build macro UPSAMPLE_HOLD_EN: non-zero phases repeat the last popped sample instead of zero.
module upsample_ctrl #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned FACTOR = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PRIME  = 2,
  localparam int unsigned PW    = ($clog2(FACTOR) < 1) ? 1 : $clog2(FACTOR),
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x_in,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic             enable,
  input  logic             underrun_clr,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             sample_strobe,
  output logic [PW-1:0]    phase,
  output logic [LW-1:0]    level,
  output logic             underrun
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ph;
  logic [AW-1:0]    wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push, pop, ur_hit, ph_last;

  assign x_ready = (level != LW'(DEPTH));

  // Handshake decode and next-state logic
  always_comb begin
    state_d = state_q;
    push    = x_valid && x_ready;
    ph_last = (ph == PW'(FACTOR - 1));
    pop     = (state_q == S_RUN) && (ph == '0) && (level != '0);
    ur_hit  = (state_q == S_RUN) && (ph == '0) && (level == '0);
    case (state_q)
      S_IDLE:  if (enable) state_d = S_PRIME;
      S_PRIME: begin
        if (!enable)                    state_d = S_IDLE;
        else if (level >= LW'(PRIME))   state_d = S_RUN;
      end
      S_RUN:   if (ph_last && !enable)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Storage carries no reset; pointers and level define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= x_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Phase counter and registered output stream
  always_ff @(posedge clk) begin
    if (reset) begin
      ph            <= '0;
      y             <= '0;
      y_valid       <= 1'b0;
      sample_strobe <= 1'b0;
      phase         <= '0;
    end else if (state_q == S_RUN) begin
      ph      <= ph_last ? '0 : ph + PW'(1);
      y_valid <= 1'b1;
      phase   <= ph;
      if (ph == '0) begin
        sample_strobe <= 1'b1;
        y             <= pop ? mem[rptr] : '0;
      end else begin
        sample_strobe <= 1'b0;
`ifdef UPSAMPLE_HOLD_EN
        y             <= y;
`else
        y             <= '0;
`endif
      end
    end else begin
      ph            <= '0;
      y             <= '0;
      y_valid       <= 1'b0;
      sample_strobe <= 1'b0;
      phase         <= '0;
    end
  end

  // Sticky underrun; a new underrun beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset)             underrun <= 1'b0;
    else if (ur_hit)       underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

endmodule

// File: tb/tb_upsample_ctrl.sv
// Bench for upsample_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_upsample_ctrl;
  localparam int unsigned WIDTH  = 18;
  localparam int unsigned FACTOR = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PRIME  = 2;
  localparam int unsigned PW     = 2;
  localparam int unsigned LW     = 3;
  localparam int unsigned OW     = WIDTH + PW + LW + 4;

  logic             clk, reset;
  logic [WIDTH-1:0] x_in;
  logic             x_valid, x_ready, enable, underrun_clr;
  logic [WIDTH-1:0] y;
  logic             y_valid, sample_strobe, underrun;
  logic [PW-1:0]    phase;
  logic [LW-1:0]    level;

  upsample_ctrl #(.WIDTH(WIDTH), .FACTOR(FACTOR), .DEPTH(DEPTH), .PRIME(PRIME)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .enable(enable), .underrun_clr(underrun_clr), .y(y), .y_valid(y_valid),
    .sample_strobe(sample_strobe), .phase(phase), .level(level), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 priming, 2 running; FIFO as a queue
  logic [WIDTH-1:0] mq [$];
  int               m_mode = 0;
  int               m_ph = 0;
  logic [WIDTH-1:0] e_y = '0;
  logic             e_yv = 1'b0, e_st = 1'b0, e_ur = 1'b0;
  int               e_phase = 0;
  int               total = 0, bad = 0, cyc = 0;

  wire [OW-1:0] obs = {y, y_valid, sample_strobe, phase, level, underrun, x_ready};

  function automatic logic [OW-1:0] exp_vec();
    return {e_y, e_yv, e_st, PW'(e_phase), LW'(mq.size()), e_ur, (mq.size() != DEPTH)};
  endfunction

  // Advance one clock: update the model with the inputs seen at the edge, then settle
  task automatic tick();
    int lvl;
    int old_mode;
    @(posedge clk);
    cyc++;
    if (reset) begin
      mq.delete();
      m_mode = 0; m_ph = 0; e_y = '0; e_yv = 0; e_st = 0; e_phase = 0; e_ur = 0;
    end else begin
      lvl = mq.size();
      old_mode = m_mode;
      if (m_mode == 2) begin
        e_yv = 1; e_phase = m_ph;
        if (m_ph == 0) begin
          e_st = 1;
          e_y  = (lvl != 0) ? mq[0] : '0;
        end else begin
          e_st = 0;
`ifndef UPSAMPLE_HOLD_EN
          e_y  = '0;
`endif
        end
      end else begin
        e_y = '0; e_yv = 0; e_st = 0; e_phase = 0;
      end
      if (m_mode == 2 && m_ph == 0 && lvl == 0) e_ur = 1;
      else if (underrun_clr)                    e_ur = 0;
      if (m_mode == 2 && m_ph == 0 && lvl != 0) void'(mq.pop_front());
      if (x_valid && lvl != DEPTH) mq.push_back(x_in);
      case (m_mode)
        0: if (enable) m_mode = 1;
        1: if (!enable) m_mode = 0; else if (lvl >= PRIME) m_mode = 2;
        default: if (m_ph == FACTOR - 1 && !enable) m_mode = 0;
      endcase
      m_ph = (old_mode == 2) ? (m_ph + 1) % FACTOR : 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; x_valid = 0; enable = 0; underrun_clr = 0; x_in = '0;
    tick(); tick();
    reset = 0;
    total++;
    if (obs !== exp_vec()) begin bad++; $display("FAIL reset got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] vals [4];
    int exp_seq [16] = '{100,0,0,0,-200,0,0,0,300,0,0,0,-400,0,0,0};
    logic [WIDTH-1:0] seq [$];
    int got_n = 0;
    vals = '{WIDTH'(100), WIDTH'(-200), WIDTH'(300), WIDTH'(-400)};
    for (int i = 0; i < 5; i++) begin
      x_valid = 1; x_in = (i < 4) ? vals[i] : WIDTH'(999);
      tick();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL fill cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    x_valid = 0;
    total++;
    if (x_ready !== 1'b0 || level !== LW'(4)) begin
      bad++; $display("FAIL full_flag got rdy=%b lvl=%0d exp rdy=0 lvl=4", x_ready, level);
    end
    enable = 1;
    for (int c = 0; c < 40 && seq.size() < 16; c++) begin
      tick();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (y_valid) begin
        seq.push_back(y);
        total++;
        if (phase !== PW'(got_n % 4) || sample_strobe !== (got_n % 4 == 0)) begin
          bad++; $display("FAIL basic_phase n=%0d got ph=%0d st=%b", got_n, phase, sample_strobe);
        end
        got_n++;
      end
    end
    total++;
    if (seq.size() != 16) begin bad++; $display("FAIL basic_count got=%0d exp=16", seq.size()); end
    for (int i = 0; i < seq.size(); i++) begin
      total++;
      if ($signed(seq[i]) !== exp_seq[i]) begin
        bad++; $display("FAIL basic_seq i=%0d got=%0d exp=%0d", i, $signed(seq[i]), exp_seq[i]);
      end
    end
  endtask

  task automatic test_underrun();
    bit saw7 = 0;
    for (int c = 0; c < 14; c++) begin
      underrun_clr = (c == 4 || c == 5);
      x_valid = (c == 6); x_in = WIDTH'(7);
      tick();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL underrun cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (c == 0) begin
        total++;
        if (underrun !== 1'b1 || sample_strobe !== 1'b1 || y !== '0) begin
          bad++; $display("FAIL underrun_flag got ur=%b st=%b y=%h exp 1 1 0", underrun, sample_strobe, y);
        end
      end
      if (sample_strobe && y === WIDTH'(7)) saw7 = 1;
    end
    underrun_clr = 0; x_valid = 0;
    total++;
    if (!saw7) begin bad++; $display("FAIL underrun_recover got no 7 exp 7"); end
  endtask

  task automatic test_stop();
    for (int c = 0; c < 8 && m_ph != 1; c++) tick();
    enable = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL stop cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    x_valid = 1; x_in = WIDTH'(11);
    tick();
    x_valid = 0; enable = 1;
    total++;
    if (level !== LW'(1)) begin bad++; $display("FAIL stop_level got=%0d exp=1", level); end
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (obs !== exp_vec() || y_valid !== 1'b0) begin
        bad++; $display("FAIL prime_hold cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    x_valid = 1; x_in = WIDTH'(12);
    tick();
    x_valid = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL prime_run cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] seq [$];
    reset = 1; enable = 0; tick(); reset = 0;
    x_valid = 1; x_in = WIDTH'(18'h1FFFF); tick();
    x_in = WIDTH'(18'h20000); tick();
    x_valid = 0; enable = 1;
    for (int c = 0; c < 10 && !(m_mode == 2 && m_ph == 0); c++) tick();
    x_valid = 1; x_in = WIDTH'(18'h00123);
    tick();
    x_valid = 0;
    total++;
    if (level !== LW'(2)) begin bad++; $display("FAIL same_edge_level got=%0d exp=2", level); end
    if (sample_strobe) seq.push_back(y);
    for (int c = 0; c < 12; c++) begin
      tick();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL same_edge cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (sample_strobe) seq.push_back(y);
    end
    total++;
    if (seq.size() < 3 || seq[0] !== 18'h1FFFF || seq[1] !== 18'h20000 || seq[2] !== 18'h00123) begin
      bad++; $display("FAIL fifo_order got n=%0d exp 1ffff,20000,00123", seq.size());
    end
  endtask

  task automatic test_reset_mid();
    reset = 1; enable = 0; tick(); reset = 0;
    for (int i = 0; i < 4; i++) begin x_valid = 1; x_in = WIDTH'(i + 40); tick(); end
    x_valid = 0; enable = 1;
    for (int c = 0; c < 12 && !(m_mode == 2 && m_ph == 2); c++) tick();
    total++;
    if (level !== LW'(3) || phase !== PW'(1)) begin
      bad++; $display("FAIL mid_setup got lvl=%0d ph=%0d exp lvl=3 ph=1", level, phase);
    end
    reset = 1;
    tick();
    reset = 0; enable = 0;
    total++;
    if (obs !== exp_vec() || level !== '0 || y_valid !== 1'b0 || y !== '0) begin
      bad++; $display("FAIL mid_reset got=%h exp=%h", obs, exp_vec());
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
  endtask

  task automatic test_random();
    reset = 1; tick(); reset = 0;
    for (int c = 0; c < 1500; c++) begin
      x_valid      = ($urandom % 3) == 0;
      x_in         = WIDTH'($urandom);
      enable       = ($urandom % 10) != 0;
      underrun_clr = ($urandom % 12) == 0;
      reset        = ($urandom % 400) == 0;
      tick();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    reset = 0; x_valid = 0; underrun_clr = 0; enable = 0;
  endtask

`ifdef UPSAMPLE_HOLD_EN
  task automatic test_hold();
    int exp_seq [8] = '{5,5,5,5,9,9,9,9};
    logic [WIDTH-1:0] seq [$];
    reset = 1; tick(); reset = 0;
    x_valid = 1; x_in = WIDTH'(5); tick();
    x_in = WIDTH'(9); tick();
    x_valid = 0; enable = 1;
    for (int c = 0; c < 20 && seq.size() < 8; c++) begin
      tick();
      if (y_valid) seq.push_back(y);
    end
    enable = 0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= seq.size() || seq[i] !== WIDTH'(exp_seq[i])) begin
        bad++; $display("FAIL hold i=%0d exp=%0d", i, exp_seq[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef UPSAMPLE_HOLD_EN
    test_hold();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/upsample_ctrl.md
# upsample_ctrl

Sequencing controller for the 18-bit signed up-sampling path. Accepts low-rate samples from the upstream stage over a valid/ready handshake and buffers them in a small FIFO. Once primed, it issues exactly one sample every FACTOR clocks and fills the remaining phases with zeros, which matches the zero-stuffed stream the interpolation filter expects. It also exports the phase index and sample strobe to downstream polyphase logic and flags underruns.

## Interface
- WIDTH, 18: sample width, two's complement.
- FACTOR, 4: up-sampling ratio; legal range 2..16.
- DEPTH, 4: FIFO depth; power of two, at least 2.
- PRIME, 2: FIFO level required to leave PRIME; legal range 1..DEPTH.
- clk, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- x_in, input, WIDTH: upstream sample (signed).
- x_valid, input, 1: upstream sample present.
- x_ready, output, 1: FIFO can accept; equals (level != DEPTH), combinational.
- enable, input, 1: run request.
- underrun_clr, input, 1: clears sticky underrun.
- y, output, WIDTH: registered output sample (signed).
- y_valid, output, 1: registered; high on every output cycle of a frame.
- sample_strobe, output, 1: registered; high when y carries a real (popped) sample slot.
- phase, output, clog2(FACTOR), min 1: registered phase of y, 0..FACTOR-1.
- level, output, clog2(DEPTH)+1: FIFO occupancy.
- underrun, output, 1: sticky; a phase-0 slot found the FIFO empty.

## Operation
- Push: x_valid && x_ready at an edge writes x_in. Pop happens only in RUN at ph==0 with level!=0. Simultaneous push and pop leaves level unchanged. A sample pushed at edge N is poppable at edge N+1 or later.
- Internal phase counter ph: 0..FACTOR-1. Increments by one per cycle in RUN and wraps FACTOR-1→0. Held at 0 outside RUN.
- States:
  - IDLE: outputs y=0, y_valid=0, sample_strobe=0, phase=0. Pushes are still accepted. Moves to PRIME when enable=1.
  - PRIME: outputs as in IDLE. Moves to RUN when level>=PRIME and enable=1. Returns to IDLE if enable=0.
  - RUN: one output per cycle.
    - ph==0: y<=pop value (0 if empty), sample_strobe<=1, phase<=0.
    - ph!=0: y<=0, sample_strobe<=0, phase<=ph.
    - y_valid<=1 on every RUN cycle.
  - Leaving RUN: when enable=0 is sampled at ph==FACTOR-1, that cycle still outputs, and the next state is IDLE. Frames are never truncated. Deasserting enable at any other phase has no effect until the frame's last phase.
- Underrun: pop attempt at ph==0 with level==0. Output is y=0 with sample_strobe=1, underrun<=1, and the block stays in RUN. If underrun_clr and a new underrun occur in the same cycle, set wins.
- FIFO contents persist across IDLE. Only reset flushes them.
- No arithmetic on samples; data passes bit-exact.

## Timing
- Reset (synchronous): state=IDLE, ph=0, level=0, y=0, y_valid=0, sample_strobe=0, phase=0, underrun=0. Reset overrides every other input, including mid-frame, and FIFO contents are discarded.
- Entering RUN: state becomes RUN at edge E. The first output (phase 0, the first popped sample) appears after edge E+1.
- Latency: FIFO head to y is one clock from the ph==0 edge.
- Throughput: one pop per FACTOR clocks in RUN.
- x_ready drops in the same cycle level reaches DEPTH. An upstream push when full is ignored.

## Configuration
- UPSAMPLE_HOLD_EN:
  - Defined: non-zero phases repeat the last popped sample (zero-order hold). An underrun slot outputs 0, and the following phases of that frame output 0.
  - Undefined (default): non-zero phases output 0 (zero-stuffing).
  - Handshake, states and strobes are identical in both builds.

## Test plan
- Reset, then push 100, -200, 300, -400 (FIFO full, x_ready=0) with enable=1. Required y sequence: 100,0,0,0,-200,0,0,0,300,0,0,0,-400,0,0,0. sample_strobe is high on each sample cycle, and phase cycles 0,1,2,3.
- Continue with no further pushes. The fifth frame gives y=0 with strobe=1 and underrun=1. Pulse underrun_clr to clear it, then push 7; the next phase-0 output is 7.
- Drop enable at phase 1. The frame completes through phase 3, then y_valid=0 and the block is in IDLE. Raise enable with level=1 (<PRIME=2); it stays in PRIME until a second push.
- Issue push and pop on the same edge at level=2. Level stays 2 and the order is preserved (FIFO ordering check with values 0x1FFFF, 0x20000).
- Assert reset mid-frame at phase 2 with level=3. The next cycle shows all outputs zero, level=0 and state IDLE.
- With UPSAMPLE_HOLD_EN defined, push 5 then 9. Required y: 5,5,5,5,9,9,9,9.
